spi_master_multi_cs: RTL and testbench

Parametrised SPI master with an integrated bit engine, configurable word width, and `NUM_CS` independently addressable chip selects. It adds programmable CS setup and hold timing and multi-word bursts under one CS assertion. It sits between register/command logic and the external SPI bus, and is the successor to the single-CS byte master with fixed 8-bit words.

---
 rtl/spi_master_multi_cs.sv | 185 ++++++++++++++++++
 tb/tb_spi_master_multi_cs.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_multi_cs.sv
// spi_master_multi_cs: SPI master with a built-in bit engine, a configurable
// word width and NUM_CS chip selects. One CS assertion can cover a burst of
// up to MAX_WORDS_PER_CS words. CS setup, hold and inactive times are set by
// parameters.
// Optional build macro SPI_MASTER_MULTI_CS_LOOPBACK_EN: when defined, the
// receive shifter samples the internal MOSI bit instead of i_SPI_MISO. Pin
// behaviour and timing are the same in both builds.
module spi_master_multi_cs #(
    parameter int SPI_MODE          = 0,
    parameter int CLKS_PER_HALF_BIT = 2,
    parameter int WORD_WIDTH        = 8,
    parameter int NUM_CS            = 4,
    parameter int MAX_WORDS_PER_CS  = 4,
    parameter int CS_SETUP_CLKS     = 1,
    parameter int CS_HOLD_CLKS      = 1,
    parameter int CS_INACTIVE_CLKS  = 1,
    localparam int CW = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
    localparam int NW = $clog2(MAX_WORDS_PER_CS + 1)
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic [CW-1:0]         i_CS_Sel,
    input  logic [NW-1:0]         i_TX_Count,
    input  logic [WORD_WIDTH-1:0] i_TX_Word,
    input  logic                  i_TX_DV,
    output logic                  o_TX_Ready,
    output logic [WORD_WIDTH-1:0] o_RX_Word,
    output logic                  o_RX_DV,
    output logic [NW-1:0]         o_RX_Count,
    output logic                  o_Busy,
    output logic                  o_SPI_Clk,
    input  logic                  i_SPI_MISO,
    output logic                  o_SPI_MOSI,
    output logic [NUM_CS-1:0]     o_SPI_CS_n
);

    localparam bit CPOL = (SPI_MODE >= 2);
    localparam bit CPHA = ((SPI_MODE % 2) == 1);
    localparam int EW   = $clog2(2 * WORD_WIDTH);
    localparam int TA   = (CS_SETUP_CLKS > CS_HOLD_CLKS) ? CS_SETUP_CLKS : CS_HOLD_CLKS;
    localparam int TB   = (CS_INACTIVE_CLKS > CLKS_PER_HALF_BIT) ? CS_INACTIVE_CLKS : CLKS_PER_HALF_BIT;
    localparam int TMAX = (TA > TB) ? TA : TB;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, WAIT, HOLD, INACTIVE} state_t;

    state_t                state;
    logic [TW-1:0]         timer;      // phase timer, also the half-period counter in SHIFT
    logic [EW-1:0]         edge_cnt;   // SCLK edges already generated in the current word
    logic [NW-1:0]         words_left;
    logic [WORD_WIDTH-1:0] tx_shift;
    logic [WORD_WIDTH-1:0] rx_shift;
    logic [WORD_WIDTH-1:0] rx_next;
    logic                  rx_bit;
    logic                  start_ok;
    logic                  load;
    logic                  half_done;
    logic                  leading;
    logic                  sample_now;
    logic                  shift_now;

`ifdef SPI_MASTER_MULTI_CS_LOOPBACK_EN
    logic unused_miso;
    assign unused_miso = i_SPI_MISO;
    assign rx_bit      = o_SPI_MOSI;
`else
    assign rx_bit      = i_SPI_MISO;
`endif

    // A start is taken only for a legal word count and an existing slave index.
    assign start_ok   = (state == IDLE) && i_TX_DV && (i_TX_Count != '0) &&
                        (int'(i_TX_Count) <= MAX_WORDS_PER_CS) && (int'(i_CS_Sel) < NUM_CS);
    assign load       = start_ok || ((state == WAIT) && i_TX_DV);
    assign half_done  = (state == SHIFT) && (timer == TW'(CLKS_PER_HALF_BIT - 1));
    assign leading    = ~edge_cnt[0];
    assign sample_now = half_done && (leading ^ CPHA);
    assign shift_now  = half_done && (leading == CPHA);
    assign rx_next    = {rx_shift[WORD_WIDTH-2:0], rx_bit};
    assign o_Busy     = (state != IDLE);
    assign o_TX_Ready = (state == IDLE) || (state == WAIT);

    // Data shifters. A partial word left by a reset is overwritten by the next word.
    always_ff @(posedge i_Clk) begin
        if (load) begin
            tx_shift <= CPHA ? i_TX_Word : (i_TX_Word << 1);
        end else if (shift_now) begin
            tx_shift <= tx_shift << 1;
        end
        if (sample_now) begin
            rx_shift <= rx_next;
        end
    end

    // Transaction FSM. Drives CS, SCLK, MOSI and the receive strobes.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state      <= IDLE;
            timer      <= '0;
            edge_cnt   <= '0;
            words_left <= '0;
            o_SPI_CS_n <= '1;
            o_SPI_Clk  <= CPOL;
            o_SPI_MOSI <= 1'b0;
            o_RX_Word  <= '0;
            o_RX_DV    <= 1'b0;
            o_RX_Count <= '0;
        end else begin
            o_RX_DV <= 1'b0;
            if (o_RX_DV) begin
                o_RX_Count <= o_RX_Count + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        state      <= SETUP;
                        timer      <= '0;
                        words_left <= i_TX_Count;
                        o_RX_Count <= '0;
                        o_SPI_CS_n <= ~(NUM_CS'(1) << i_CS_Sel);
                        if (!CPHA) begin
                            o_SPI_MOSI <= i_TX_Word[WORD_WIDTH-1];
                        end
                    end
                end
                SETUP: begin
                    if (timer == TW'(CS_SETUP_CLKS - 1)) begin
                        state    <= SHIFT;
                        timer    <= '0;
                        edge_cnt <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                SHIFT: begin
                    if (half_done) begin
                        timer     <= '0;
                        o_SPI_Clk <= ~o_SPI_Clk;
                        edge_cnt  <= edge_cnt + 1'b1;
                        if (shift_now) begin
                            o_SPI_MOSI <= tx_shift[WORD_WIDTH-1];
                        end
                        if (edge_cnt == EW'(2 * WORD_WIDTH - 1)) begin
                            edge_cnt   <= '0;
                            o_RX_DV    <= 1'b1;
                            o_RX_Word  <= CPHA ? rx_next : rx_shift;
                            words_left <= words_left - 1'b1;
                            state      <= (words_left == NW'(1)) ? HOLD : WAIT;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                WAIT: begin
                    if (i_TX_DV) begin
                        state    <= SHIFT;
                        timer    <= '0;
                        edge_cnt <= '0;
                        if (!CPHA) begin
                            o_SPI_MOSI <= i_TX_Word[WORD_WIDTH-1];
                        end
                    end
                end
                HOLD: begin
                    if (timer == TW'(CS_HOLD_CLKS - 1)) begin
                        state      <= INACTIVE;
                        timer      <= '0;
                        o_SPI_CS_n <= '1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                INACTIVE: begin
                    if (timer == TW'(CS_INACTIVE_CLKS - 1)) begin
                        state <= IDLE;
                        timer <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_multi_cs.sv
// Testbench for spi_master_multi_cs. It runs six instances with different
// modes, word widths and CS timings. Each instance has a simple slave that
// drives MISO from a test word and captures MOSI on its own sample edge.
`timescale 1ns/1ps
module tb_spi_master_multi_cs;

    localparam int NI   = 6;
    localparam int CPHB = 2;

    function automatic int p_w(input int g);     return (g == 0 || g == 5) ? 8 : 12; endfunction
    function automatic int p_mode(input int g);  return (g >= 2 && g <= 4) ? g - 1 : 0; endfunction
    function automatic int p_setup(input int g); return (g == 5) ? 3 : 1; endfunction
    function automatic int p_hold(input int g);  return (g == 5) ? 2 : 1; endfunction
    function automatic int p_inact(input int g); return (g == 5) ? 4 : 1; endfunction
    function automatic int p_ncs(input int g);   return (g == 5) ? 3 : 4; endfunction

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]  cs_sel  [NI];
    logic [2:0]  tx_cnt  [NI];
    logic [11:0] tx_word [NI];
    logic        tx_dv   [NI];
    logic [11:0] slv     [NI];
    logic        tx_rdy  [NI];
    logic [11:0] rx_word [NI];
    logic        rx_dv   [NI];
    logic [2:0]  rx_cnt  [NI];
    logic        busy    [NI];
    logic        sclk    [NI];
    logic        mosi    [NI];
    logic [3:0]  cs_n    [NI];
    logic [11:0] mcap    [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int W    = p_w(g);
        localparam int M    = p_mode(g);
        localparam int NC   = p_ncs(g);
        localparam bit CPOL = (M >= 2);
        localparam bit CPHA = ((M % 2) == 1);

        logic [W-1:0]  rxw;
        logic [NC-1:0] csn;
        logic [3:0]    csx;
        logic          miso_l;
        logic          sp = 1'b0;
        int            nl = 0;
        int            nt = 0;
        int            bi;
        logic [11:0]   cap = '0;
        logic          lead_p;
        logic          trail_p;

        spi_master_multi_cs #(
            .SPI_MODE(M), .CLKS_PER_HALF_BIT(CPHB), .WORD_WIDTH(W), .NUM_CS(NC),
            .MAX_WORDS_PER_CS(4), .CS_SETUP_CLKS(p_setup(g)), .CS_HOLD_CLKS(p_hold(g)),
            .CS_INACTIVE_CLKS(p_inact(g))
        ) u_dut (
            .i_Clk(clk), .i_Rst(rst), .i_CS_Sel(cs_sel[g]), .i_TX_Count(tx_cnt[g]),
            .i_TX_Word(tx_word[g][W-1:0]), .i_TX_DV(tx_dv[g]), .o_TX_Ready(tx_rdy[g]),
            .o_RX_Word(rxw), .o_RX_DV(rx_dv[g]), .o_RX_Count(rx_cnt[g]), .o_Busy(busy[g]),
            .o_SPI_Clk(sclk[g]), .i_SPI_MISO(miso_l), .o_SPI_MOSI(mosi[g]), .o_SPI_CS_n(csn)
        );

        always_comb begin
            csx = 4'hF;
            csx[NC-1:0] = csn;
        end
        assign cs_n[g]    = csx;
        assign rx_word[g] = 12'(rxw);
        assign mcap[g]    = cap;

        // The slave reacts in the same cycle the SCLK edge appears.
        assign lead_p  = (sclk[g] != sp) && (sclk[g] != CPOL);
        assign trail_p = (sclk[g] != sp) && (sclk[g] == CPOL);

        always_comb begin
            bi     = 0;
            miso_l = 1'b0;
            if (!CPHA) bi = (nt + int'(trail_p)) % W;
            else if (nl + int'(lead_p) > 0) bi = (nl + int'(lead_p) - 1) % W;
            miso_l = slv[g][W-1-bi];
        end

        always @(posedge clk) begin
            if (&csn) begin
                nl <= 0;
                nt <= 0;
                sp <= CPOL;
            end else begin
                sp <= sclk[g];
                if (lead_p)  nl <= nl + 1;
                if (trail_p) nt <= nt + 1;
                if ((lead_p && !CPHA) || (trail_p && CPHA)) cap <= {cap[10:0], mosi[g]};
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] exp_rx(input logic [11:0] tx, input logic [11:0] s);
`ifdef SPI_MASTER_MULTI_CS_LOOPBACK_EN
        return tx;
`else
        return s;
`endif
    endfunction

    // Runs one transaction of n words on instance g and checks data and timing.
    // Cycle 0 is the cycle right after the accepting edge.
    task automatic xfer(input int g, input int sel, input int n,
                        input logic [11:0] w0, input logic [11:0] w1, input logic [11:0] w2,
                        input int gap);
        logic [11:0] wl [3];
        logic [11:0] mask;
        logic [3:0]  cs_exp;
        logic        cpol;
        int w, cyc, sent, nrx, first_edge, first_dv, last_dv, cs_high, rdy, wait_cyc;
        bit done, bad_wait, bad_cs;
        wl[0] = w0; wl[1] = w1; wl[2] = w2;
        w      = p_w(g);
        mask   = 12'((1 << w) - 1);
        cpol   = (p_mode(g) >= 2);
        cs_exp = 4'hF & ~(4'b0001 << sel);
        first_edge = -1; first_dv = -1; last_dv = -1; cs_high = -1; rdy = -1;
        nrx = 0; wait_cyc = 0; done = 0; bad_wait = 0; bad_cs = 0;
        cs_sel[g]  = 2'(sel);
        tx_cnt[g]  = 3'(n);
        tx_word[g] = wl[0];
        tx_dv[g]   = 1'b1;
        sent       = 1;
        tick();
        tx_dv[g] = 1'b0;
        check($sformatf("cs_low g%0d", g), 32'(cs_n[g]), 32'(cs_exp));
        cyc = 0;
        while (cyc < 3000 && !done) begin
            if (first_edge < 0 && sclk[g] != cpol) first_edge = cyc;
            if (rx_dv[g]) begin
                if (nrx < 3) begin
                    check($sformatf("rx_word g%0d w%0d", g, nrx), 32'(rx_word[g]),
                          32'(exp_rx(wl[nrx] & mask, slv[g] & mask)));
                    check($sformatf("rx_count g%0d w%0d", g, nrx), 32'(rx_cnt[g]), 32'(nrx));
                end
                if (first_dv < 0) first_dv = cyc;
                last_dv = cyc;
                nrx++;
            end
            if (cs_high < 0 && cs_n[g] == 4'hF) cs_high = cyc;
            if (cs_high < 0 && cs_n[g] != cs_exp) bad_cs = 1;
            if (!busy[g]) begin
                rdy  = cyc;
                done = 1;
            end else if (tx_rdy[g]) begin
                if (sclk[g] != cpol || cs_n[g] != cs_exp) bad_wait = 1;
                if (wait_cyc == gap && sent < n) begin
                    tx_word[g] = wl[sent];
                    tx_dv[g]   = 1'b1;
                    sent++;
                    wait_cyc = 0;
                end else begin
                    wait_cyc++;
                end
            end
            if (!done) begin
                tick();
                tx_dv[g] = 1'b0;
                cyc++;
            end
        end
        check($sformatf("finished g%0d", g), 32'(done), 32'd1);
        check($sformatf("n_rx g%0d", g), 32'(nrx), 32'(n));
        check($sformatf("first_edge g%0d", g), 32'(first_edge), 32'(p_setup(g) + CPHB));
        check($sformatf("word_len g%0d", g), 32'(first_dv), 32'(p_setup(g) + 2 * w * CPHB));
        check($sformatf("cs_hold g%0d", g), 32'(cs_high - last_dv), 32'(p_hold(g)));
        check($sformatf("inactive g%0d", g), 32'(rdy - cs_high), 32'(p_inact(g)));
        check($sformatf("cs_steady g%0d", g), 32'(bad_cs), 32'd0);
        if (n > 1) check($sformatf("wait_idle g%0d", g), 32'(bad_wait), 32'd0);
        check($sformatf("mosi g%0d", g), 32'(mcap[g] & mask), 32'(wl[n-1] & mask));
        check($sformatf("sclk_idle g%0d", g), 32'(sclk[g]), 32'(cpol));
    endtask

    // Requests a start that must be ignored and checks that nothing moves.
    task automatic reject(input int g, input int sel, input int cnt);
        cs_sel[g]  = 2'(sel);
        tx_cnt[g]  = 3'(cnt);
        tx_word[g] = 12'h0F0;
        tx_dv[g]   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 1) tx_dv[g] = 1'b0;
            check($sformatf("rej_cs g%0d c%0d", g, i), 32'(cs_n[g]), 32'hF);
            check($sformatf("rej_busy g%0d c%0d", g, i), 32'(busy[g]), 32'd0);
            check($sformatf("rej_rdy g%0d c%0d", g, i), 32'(tx_rdy[g]), 32'd1);
        end
        tx_dv[g] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  edges;
        int  dv_seen;
        logic prev;
        rst = 1'b1;
        for (int g = 0; g < NI; g++) begin
            cs_sel[g] = '0; tx_cnt[g] = '0; tx_word[g] = '0; tx_dv[g] = 1'b0; slv[g] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        // Reset state of every instance
        for (int g = 0; g < NI; g++) begin
            check($sformatf("rst_cs g%0d", g), 32'(cs_n[g]), 32'hF);
            check($sformatf("rst_sclk g%0d", g), 32'(sclk[g]), 32'(p_mode(g) >= 2));
            check($sformatf("rst_mosi g%0d", g), 32'(mosi[g]), 32'd0);
            check($sformatf("rst_rxw g%0d", g), 32'(rx_word[g]), 32'd0);
            check($sformatf("rst_rxdv g%0d", g), 32'(rx_dv[g]), 32'd0);
            check($sformatf("rst_rxcnt g%0d", g), 32'(rx_cnt[g]), 32'd0);
            check($sformatf("rst_busy g%0d", g), 32'(busy[g]), 32'd0);
            check($sformatf("rst_rdy g%0d", g), 32'(tx_rdy[g]), 32'd1);
        end

        // Single word, mode 0, CS 2
        slv[0] = 12'h03C;
        xfer(0, 2, 1, 12'h0A5, 12'h000, 12'h000, 0);

        // All four modes with 12-bit words
        for (int g = 1; g <= 4; g++) begin
            slv[g] = 12'h5C3;
            xfer(g, 1, 1, 12'hABC, 12'h000, 12'h000, 0);
        end

        // Three-word burst with a 20-cycle gap before the second word
        slv[0] = 12'h096;
        xfer(0, 1, 3, 12'h011, 12'h022, 12'h033, 20);

        // Starts that must be ignored
        reject(0, 0, 0);
        reject(0, 1, 5);
        reject(5, 3, 1);

        // Reset at the 5th SCLK edge of a word
        slv[0] = 12'h0C3;
        cs_sel[0] = 2'd0; tx_cnt[0] = 3'd1; tx_word[0] = 12'h0FF; tx_dv[0] = 1'b1;
        tick();
        tx_dv[0] = 1'b0;
        edges = 0;
        prev  = sclk[0];
        for (int i = 0; i < 200 && edges < 5; i++) begin
            tick();
            if (sclk[0] != prev) edges++;
            prev = sclk[0];
        end
        check("rst_mid_edges", 32'(edges), 32'd5);
        rst = 1'b1;
        #1;
        check("rst_mid_cs", 32'(cs_n[0]), 32'hF);
        check("rst_mid_sclk", 32'(sclk[0]), 32'd0);
        check("rst_mid_busy", 32'(busy[0]), 32'd0);
        check("rst_mid_rdy", 32'(tx_rdy[0]), 32'd1);
        dv_seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (rx_dv[0]) dv_seen++;
        end
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (rx_dv[0]) dv_seen++;
        end
        check("rst_mid_no_dv", 32'(dv_seen), 32'd0);
        xfer(0, 0, 1, 12'h05A, 12'h000, 12'h000, 0);

        // Long setup, hold and inactive times on the 3-CS instance
        slv[5] = 12'h0E1;
        xfer(5, 2, 1, 12'h05A, 12'h000, 12'h000, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
